// File: rtl/booth_seq_divider_pkg.sv
// ----------------------------------------------------------------------------
// booth_seq_divider_pkg
// Shared arithmetic-cluster definitions used by the sequential divider (and
// the neighbouring multipliers):
//   - state_e       : control FSM encoding (IDLE / RUN / FIX)
//   - DIV_MAX_W     : widest operand the sign helper supports
//   - cond_negate() : two's-complement conditional negate, used for both
//                     absolute value (neg = sign bit) and sign fix-up
// ----------------------------------------------------------------------------
package booth_seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   // Callers zero-extend their N-bit operand to this width and cast the
   // result back to N bits; negation modulo 2^64 truncated to N bits equals
   // negation modulo 2^N, so one helper serves every operand width <= 64.
   localparam int DIV_MAX_W = 64;

   function automatic logic [DIV_MAX_W-1:0] cond_negate(
      input logic [DIV_MAX_W-1:0] value,
      input logic                 neg
   );
      logic [DIV_MAX_W-1:0] result;
      if (neg) begin
         result = ~value + {{(DIV_MAX_W-1){1'b0}}, 1'b1};
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage : booth_seq_divider_pkg

// File: rtl/booth_seq_divider_div_step.sv
// ----------------------------------------------------------------------------
// booth_seq_divider_div_step
// One combinational restoring-division step on operand magnitudes.
//   prem_i  [N:0]   : partial remainder before the step
//   bit_i           : next dividend bit shifted in at the LSB
//   dvsr_i  [N-1:0] : divisor magnitude
//   prem_o  [N:0]   : partial remainder after shift/compare/subtract
//   q_bit_o         : quotient bit produced by this step
// ----------------------------------------------------------------------------
module booth_seq_divider_div_step #(
   parameter int N = 32
) (
   input  logic [N:0]   prem_i,
   input  logic         bit_i,
   input  logic [N-1:0] dvsr_i,
   output logic [N:0]   prem_o,
   output logic         q_bit_o
);

   logic [N+1:0] shifted_s;
   logic [N+1:0] dvsr_ext_s;
   logic [N:0]   diff_s;

   // Shift in the next dividend bit, then subtract the divisor if it fits.
   always_comb begin
      // The shifted value is kept one bit wider than prem so the compare
      // sees every bit; the invariant prem < divisor keeps the top bit clear.
      shifted_s  = {prem_i, bit_i};
      dvsr_ext_s = {2'b00, dvsr_i};
      diff_s     = shifted_s[N:0] - dvsr_ext_s[N:0];
      if (shifted_s >= dvsr_ext_s) begin
         prem_o  = diff_s;
         q_bit_o = 1'b1;
      end else begin
         prem_o  = shifted_s[N:0];
         q_bit_o = 1'b0;
      end
   end

endmodule : booth_seq_divider_div_step

// File: rtl/booth_seq_divider.sv
// ----------------------------------------------------------------------------
// booth_seq_divider
// Sequential signed divider: one quotient bit per clock (restoring
// shift-subtract on magnitudes) followed by a sign fix-up cycle. Results
// follow Verilog '/' and '%' (truncate toward zero, remainder takes the
// dividend's sign).
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request; operands sampled on the same edge when idle
//   dividend     : signed N-bit dividend
//   divisor      : signed N-bit divisor
//   quotient     : signed N-bit quotient (registered, held until next result)
//   remainder    : signed N-bit remainder (registered, held until next result)
//   busy         : operation in progress
//   done         : one-cycle pulse when quotient/remainder are updated
//   div_by_zero  : one-cycle pulse with done when the divisor was zero
// Supports 4 <= N <= DIV_MAX_W.
// ----------------------------------------------------------------------------
module booth_seq_divider
   import booth_seq_divider_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   state_e         state_q,     state_d;
   logic [N:0]     prem_q,      prem_d;
   // Holds the dividend magnitude while it shifts out MSB-first; quotient
   // bits shift in at the LSB. In the divide-by-zero path it holds the raw
   // dividend so it can be returned as the remainder.
   logic [N-1:0]   qbits_q,     qbits_d;
   logic [N-1:0]   dvsr_q,      dvsr_d;
   logic [CW-1:0]  count_q,     count_d;
   logic           neg_quo_q,   neg_quo_d;
   logic           neg_rem_q,   neg_rem_d;
   logic           dz_q,        dz_d;
   logic [N-1:0]   quotient_q,  quotient_d;
   logic [N-1:0]   remainder_q, remainder_d;
   logic           busy_q,      busy_d;
   logic           done_q,      done_d;
   logic           dz_out_q,    dz_out_d;

   logic [N:0]     step_prem_s;
   logic           step_qbit_s;

   booth_seq_divider_div_step #(
      .N (N)
   ) u_div_step (
      .prem_i  (prem_q),
      .bit_i   (qbits_q[N-1]),
      .dvsr_i  (dvsr_q),
      .prem_o  (step_prem_s),
      .q_bit_o (step_qbit_s)
   );

   // Next-state, datapath and output logic for the IDLE/RUN/FIX controller.
   always_comb begin
      state_d     = state_q;
      prem_d      = prem_q;
      qbits_d     = qbits_q;
      dvsr_d      = dvsr_q;
      count_d     = count_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = 1'b0;
      dz_out_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == {N{1'b0}}) begin
                  dz_d    = 1'b1;
                  qbits_d = dividend;
                  state_d = FIX;
               end else begin
                  dz_d      = 1'b0;
                  qbits_d   = N'(cond_negate(DIV_MAX_W'(dividend), dividend[N-1]));
                  dvsr_d    = N'(cond_negate(DIV_MAX_W'(divisor), divisor[N-1]));
                  neg_quo_d = dividend[N-1] ^ divisor[N-1];
                  neg_rem_d = dividend[N-1];
                  prem_d    = {(N+1){1'b0}};
                  count_d   = CW'(N);
                  state_d   = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            prem_d  = step_prem_s;
            qbits_d = {qbits_q[N-2:0], step_qbit_s};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = FIX;
            end else begin
               state_d = RUN;
            end
         end

         FIX: begin
            if (dz_q) begin
               quotient_d  = {N{1'b1}};
               remainder_d = qbits_q;
               dz_out_d    = 1'b1;
            end else begin
               // MIN / -1 wraps naturally: qmag = 2^(N-1), negation modulo
               // 2^N leaves it at MIN. A zero magnitude negates to zero.
               quotient_d  = N'(cond_negate(DIV_MAX_W'(qbits_q), neg_quo_q));
               remainder_d = N'(cond_negate(DIV_MAX_W'(prem_q[N-1:0]), neg_rem_q));
               dz_out_d    = 1'b0;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // busy tracks the registered state, so it drops on the edge done rises.
      busy_d = (state_d != IDLE);
   end

   // State, datapath and registered-output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prem_q      <= {(N+1){1'b0}};
         qbits_q     <= {N{1'b0}};
         dvsr_q      <= {N{1'b0}};
         count_q     <= {CW{1'b0}};
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         dz_q        <= 1'b0;
         quotient_q  <= {N{1'b0}};
         remainder_q <= {N{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dz_out_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         prem_q      <= prem_d;
         qbits_q     <= qbits_d;
         dvsr_q      <= dvsr_d;
         count_q     <= count_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dz_out_q    <= dz_out_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dz_out_q;

endmodule : booth_seq_divider

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
- Sequential signed integer divider; the inverse operation to the team's sequential Booth multiplier.
- Computes one quotient bit per clock using restoring shift-subtract on operand magnitudes, then applies the sign correction.
- Accepts operands through a start/busy/done handshake. Sits in the arithmetic-unit cluster next to the multipliers.
- Result convention matches Verilog `/` and `%`: quotient truncates toward zero; remainder takes the sign of the dividend.

Parameters:
- N, 32, operand width in bits (dividend, divisor, quotient and remainder are all N bits; N >= 4).

Ports:
- clk  input  1  clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; operands are sampled on the same edge.
- dividend  input  N  signed dividend.
- divisor  input  N  signed divisor.
- quotient  output  N  signed quotient (registered).
- remainder  output  N  signed remainder (registered).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- div_by_zero  output  1  set with done when the divisor was 0.

Behaviour:
- Reset: asynchronous, active-high, clock: clk. While rst=1, state=IDLE and quotient, remainder, busy, done, div_by_zero are all 0. Reset mid-operation aborts the operation with no done.
- States: IDLE, RUN, FIX.
- IDLE, start=1, divisor!=0 (edge 0):
  - Latch |dividend| and |divisor| as N-bit unsigned values; |MIN| = 2^(N-1) fits.
  - Latch sign_q = dividend[N-1]^divisor[N-1] and sign_r = dividend[N-1].
  - Clear the (N+1)-bit partial remainder; set count=N; go to RUN; busy=1.
- IDLE, start=1, divisor==0: go to FIX with the dz flag set. Done occurs on edge 1.
- RUN, each edge:
  - Shift {prem, qbits} left by 1, bringing in the dividend MSB.
  - If prem >= |divisor|: prem -= |divisor| and the quotient bit = 1; else the quotient bit = 0.
  - count decrements; after the N-th RUN edge (edge N), go to FIX.
- FIX, one edge (edge N+1):
  - quotient = sign_q ? -qmag : qmag.
  - remainder = sign_r ? -rmag : rmag.
  - Both are truncated to N bits.
  - done=1, busy=0, state=IDLE.
  - Divide by zero: quotient = all ones, remainder = dividend as latched, div_by_zero=1.
- Latency:
  - Normal operation: done is high in the cycle after edge N+1 (N+2 edges from start, inclusive).
  - Divide by zero: done is high after edge 1.
- Flag timing:
  - done and div_by_zero are high for exactly one cycle.
  - div_by_zero clears on the next edge.
  - quotient and remainder hold until the next FIX or reset.
- busy is high after edge 0 through edge N. It deasserts on the same edge that done asserts.
- start while busy=1 is ignored (no queuing; operands are not resampled).
- start in the cycle done=1 is accepted (state is IDLE). Back-to-back throughput is one result per N+2 cycles.
- Overflow: MIN / -1 wraps to quotient=MIN, remainder=0, with no flag.
- Zero dividend gives quotient 0 and remainder 0. A negative result of zero magnitude stays 0.
- Width rules:
  - Partial remainder is N+1 bits so the compare/subtract never overflows.
  - Magnitudes are unsigned N bits.
  - Sign negation is two's complement modulo 2^N.

Decomposition:
- Shared arithmetic package holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, FIX=2'd2;
  - a helper function for two's-complement absolute value/negate, shared with the multipliers.
- One natural sub-module: div_step, a combinational (N+1)-bit shift-compare-subtract stage. It produces the next prem and the quotient bit, and is instantiated once inside the RUN datapath.
- Control FSM, counter and sign fix-up stay in booth_seq_divider.

Test Plan:
- N=32:
  - 100/7 -> quotient 14, remainder 2, done on edge 33.
  - -100/7 -> -14, -2.
  - 100/-7 -> -14, 2.
  - -100/-7 -> 14, -2.
- N=32:
  - 0x80000000 / -1 -> quotient 0x80000000, remainder 0, div_by_zero=0.
  - 0x80000000 / 1 -> 0x80000000, 0.
  - 7/100 -> 0, 7.
- Divide by zero, N=32, 55/0 -> done after edge 1, div_by_zero=1, quotient 0xFFFFFFFF, remainder 55. Flags clear on the following edge.
- 100/7 started, then start with 9/3 pulsed at edge 5 -> ignored; result still 14, 2.
- start with 9/3 in the done cycle -> accepted; 3, 0 arrive N+2 edges later.
- rst asserted at edge 10 of an operation:
  - all outputs go to 0 immediately (asynchronously);
  - no done pulse appears;
  - a fresh 20/6 after reset -> 3, 2.
- Randomized 10k pairs against the Verilog `/` and `%` reference model, including MIN, MAX, ±1 and 0 corners.
